// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: branch condition encodings, CCR flag bit
// positions and branch-controller FSM states.
package pipe_pkg;

  typedef enum logic [1:0] {
    COND_ZF     = 2'b00,
    COND_CF     = 2'b01,
    COND_NF     = 2'b10,
    COND_ALWAYS = 2'b11
  } cond_e;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_N = 2;

  typedef enum logic [1:0] {
    IDLE,
    REDIRECT,
    FLUSH
  } state_e;

endpackage

// File: rtl/branch_ctrl_if.sv
// EX-stage branch controller bus: branch/flag inputs from the pipeline,
// CCR, redirect and flush outputs back to it.
interface branch_ctrl_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic                stall;
  logic                branch_valid;
  logic [1:0]          branch_sel;
  logic [PC_WIDTH-1:0] branch_target;
  logic [2:0]          alu_flags;
  logic [2:0]          alu_flags_we;
  logic                int_save;
  logic                rti_restore;
  logic [2:0]          ccr;
  logic                pc_load;
  logic [PC_WIDTH-1:0] pc_target;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                busy;

  modport master (
    output stall, branch_valid, branch_sel, branch_target,
           alu_flags, alu_flags_we, int_save, rti_restore,
    input  ccr, pc_load, pc_target, flush_if_id, flush_id_ex, busy
  );

  modport slave (
    input  stall, branch_valid, branch_sel, branch_target,
           alu_flags, alu_flags_we, int_save, rti_restore,
    output ccr, pc_load, pc_target, flush_if_id, flush_id_ex, busy
  );
endinterface

// File: rtl/ccr_reg.sv
// Condition-code register with interrupt shadow copy. Per-bit priority:
// restore, then ALU write, then branch clear; stall freezes both registers.
module ccr_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_stall,
  input  logic [2:0] i_we,
  input  logic [2:0] i_wdata,
  input  logic [2:0] i_clr,
  input  logic       i_save,
  input  logic       i_restore,
  output logic [2:0] o_ccr
);
  logic [2:0] r_ccr;
  logic [2:0] r_shadow;
  logic [2:0] w_ccr_nxt;

  always_comb begin
    w_ccr_nxt = r_ccr;
    for (int unsigned b = 0; b < 3; b++) begin
      if (i_restore)
        w_ccr_nxt[b] = r_shadow[b];
      else if (i_we[b])
        w_ccr_nxt[b] = i_wdata[b];
      else if (i_clr[b])
        w_ccr_nxt[b] = 1'b0;
    end
  end

  // Save reads the pre-edge CCR, so save+restore together swaps the two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ccr    <= '0;
      r_shadow <= '0;
    end else if (!i_stall) begin
      r_ccr <= w_ccr_nxt;
      if (i_save)
        r_shadow <= r_ccr;
    end
  end

  assign o_ccr = r_ccr;
endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: forwarded-flag condition mux, taken-branch
// flag clear, and a Moore FSM sequencing PC redirect plus pipeline flushes.
module branch_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned PC_WIDTH     = 32,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic           clk,
  input logic           rst_n,
  branch_ctrl_if.slave  bus
);
  localparam logic [2:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 3'(FLUSH_CYCLES - 2) : 3'd0;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [2:0]          r_cnt;
  logic [2:0]          w_cnt_nxt;
  logic [PC_WIDTH-1:0] r_pc_target;
  logic [PC_WIDTH-1:0] w_pc_target_nxt;

  logic [2:0] w_ccr;
  logic [2:0] w_eff;
  logic [2:0] w_clr;
  logic       w_cond;
  logic       w_taken;
  cond_e      w_sel;

  assign w_sel = cond_e'(bus.branch_sel);

  // Same-cycle ALU result is forwarded so a flag-setting op can feed the branch directly.
  assign w_eff = (bus.alu_flags & bus.alu_flags_we) | (w_ccr & ~bus.alu_flags_we);

  always_comb begin
    w_cond = 1'b0;
    w_clr  = '0;
    case (w_sel)
      COND_ZF:     begin w_cond = w_eff[FLAG_Z]; w_clr[FLAG_Z] = 1'b1; end
      COND_CF:     begin w_cond = w_eff[FLAG_C]; w_clr[FLAG_C] = 1'b1; end
      COND_NF:     begin w_cond = w_eff[FLAG_N]; w_clr[FLAG_N] = 1'b1; end
      COND_ALWAYS: w_cond = 1'b1;
      default:     w_cond = 1'b0;
    endcase
    if (!w_taken)
      w_clr = '0;
  end

  assign w_taken = bus.branch_valid && (r_state == IDLE) && !bus.stall && w_cond;

  ccr_reg u_ccr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_stall   (bus.stall),
    .i_we      (bus.alu_flags_we),
    .i_wdata   (bus.alu_flags),
    .i_clr     (w_clr),
    .i_save    (bus.int_save),
    .i_restore (bus.rti_restore),
    .o_ccr     (w_ccr)
  );

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_pc_target_nxt = r_pc_target;
    if (!bus.stall) begin
      case (r_state)
        IDLE: begin
          if (w_taken) begin
            w_pc_target_nxt = bus.branch_target;
            w_state_nxt     = REDIRECT;
          end
        end
        REDIRECT: begin
          if (FLUSH_CYCLES == 1) begin
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = FLUSH;
          end
        end
        FLUSH: begin
          if (r_cnt == 3'd0)
            w_state_nxt = IDLE;
          else
            w_cnt_nxt = r_cnt - 3'd1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_pc_target <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pc_target <= w_pc_target_nxt;
    end
  end

  assign bus.ccr         = w_ccr;
  assign bus.pc_load     = (r_state == REDIRECT);
  assign bus.flush_if_id = (r_state != IDLE);
  assign bus.flush_id_ex = (r_state != IDLE);
  assign bus.busy        = (r_state != IDLE);
  assign bus.pc_target   = r_pc_target;
endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch resolution and redirect controller for the five-stage pipeline, sitting at the EX stage beside the ALU. It owns the condition-code register (CCR: zero, carry, negative flags), evaluates conditional or unconditional branches against forwarded flags, and sequences the PC redirect plus IF/ID and ID/EX flushes over a fixed number of cycles. It also saves and restores the CCR across interrupt entry and return.

## Interface
- PC_WIDTH, 32, width of branch target and PC redirect bus
- FLUSH_CYCLES, 2, cycles flush stays asserted per taken branch (legal range 1..7)
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  global pipeline stall; freezes the FSM, counter and CCR
- branch_valid  in  1  EX-stage instruction is a branch
- branch_sel  in  2  condition: 00 zf, 01 cf, 10 nf, 11 always
- branch_target  in  PC_WIDTH  target address from EX
- alu_flags  in  3  {nf,cf,zf} produced by the EX-stage ALU op
- alu_flags_we  in  3  per-bit write enable for alu_flags
- int_save  in  1  interrupt entry: copy CCR to shadow
- rti_restore  in  1  return from interrupt: copy shadow to CCR
- ccr  out  3  current {nf,cf,zf}
- pc_load  out  1  redirect PC to pc_target
- pc_target  out  PC_WIDTH  registered redirect address
- flush_if_id  out  1  squash IF/ID register
- flush_id_ex  out  1  squash ID/EX register
- busy  out  1  FSM not IDLE; new branch_valid ignored

## Operation
- Effective flags: per bit, eff = alu_flags_we ? alu_flags : ccr.
- Taken = branch_valid & state==IDLE & !stall & (sel 11 or the selected eff bit is 1).
- Taken conditional branch clears the tested CCR bit at the next edge. Unconditional (11) leaves the CCR unchanged.
- CCR write priority per bit, highest first: rti_restore, then alu_flags_we, then taken-branch clear.
- int_save and rti_restore in the same cycle: the shadow takes the current CCR, and the CCR takes the old shadow (a swap).
- FSM states:
  - IDLE: on taken, latch branch_target into pc_target and go to REDIRECT.
  - REDIRECT: pc_load=1, both flushes =1. If FLUSH_CYCLES==1, next state is IDLE; else load cnt=FLUSH_CYCLES-2 and go to FLUSH.
  - FLUSH: both flushes =1, pc_load=0. If cnt==0, next state is IDLE; else cnt decrements.
- stall=1 holds state, cnt, pc_target, CCR and shadow. Outputs keep their current values, so pc_load remains asserted throughout a stalled REDIRECT.
- branch_valid outside IDLE is ignored: no flag clear, no relatch.
- Reset values: ccr=000, shadow=000, pc_target=0, pc_load=0, flush_if_id=0, flush_id_ex=0, busy=0, state=IDLE, cnt=0.
- Reset asserted mid-sequence returns the block immediately (asynchronously) to IDLE with all outputs 0.

## Timing
- Branch resolution at cycle T. pc_load, the flushes and busy are driven from state, so they rise at T+1 (registered Moore outputs).
- pc_load is high for exactly 1 unstalled cycle (T+1).
- Flushes are high for FLUSH_CYCLES unstalled cycles (T+1 .. T+FLUSH_CYCLES).
- The earliest next accepted branch is at T+FLUSH_CYCLES+1.
- CCR updates are visible on ccr one cycle after the write edge. The same-cycle ALU result is forwarded into the decision, so there is zero-bubble flag use.
- pc_target is stable from T+1 until the next accepted branch.

## Structure
- Shared package `pipe_pkg`:
  - condition encodings COND_ZF, COND_CF, COND_NF, COND_ALWAYS
  - flag bit indices FLAG_Z=0, FLAG_C=1, FLAG_N=2
  - state enum IDLE/REDIRECT/FLUSH
- Sub-module `ccr_reg`: CCR plus shadow, with per-bit write enables, clear, save/restore and stall hold. The top level holds the condition mux, the FSM and the counter.

## Test plan
- Reset, then alu_flags=001 with we=001 at T. At T+1, branch_sel=00, branch_valid=1, target=0x40.
  - pc_load=1 and pc_target=0x40 at T+2.
  - Flushes high at T+2 and T+3.
  - ccr.zf=0 after T+2.
- Forwarding: ccr=000 while the same cycle has we=001, alu_flags=001, sel=00.
  - The branch is taken; the ALU write wins over the clear, so ccr=001 afterwards.
- Not taken: sel=01 with cf=0.
  - No pc_load, no flush, busy=0, CCR unchanged.
- Stall in REDIRECT for 3 cycles.
  - pc_load and the flushes stay high for 3 cycles, then FLUSH completes with the same total of unstalled flush cycles.
  - A branch_valid presented while busy is ignored.
- Interrupt:
  - ccr=101, int_save; then ALU writes 010; then rti_restore gives ccr=101.
  - Simultaneous int_save+rti_restore swaps CCR and shadow.
- Assert rst_n=0 mid-FLUSH.
  - All outputs go to 0 asynchronously, before the next clock edge.
  - A branch is accepted on the first cycle after release.
